pw_access_ctrl: RTL

- Access sequencer for the switch-password lock. It sits between the per-switch one-shot pulse conditioners and the password checker FSM.
- Gates switch pulses into the checker and counts failed attempts.
- Enforces a timed lockout after MAX_FAILS failures, times out idle entries, and auto-relocks after a successful unlock.
- Exports state and timer values for the HEX display path.

---
 rtl/pw_pkg.sv | 16 +
 rtl/pw_access_ctrl_if.sv | 26 ++
 rtl/pw_sec_timer.sv | 37 +++
 rtl/pw_access_ctrl.sv | 149 ++++++++++++++
 4 files changed

// File: rtl/pw_pkg.sv
// rtl/pw_pkg.sv - shared types and widths for the password access sequencer
package pw_pkg;

  localparam int STATE_W      = 3;
  localparam int TIMER_W      = 7;
  localparam int SW_W         = 10;
  localparam int LOCK_KEY_BIT = 9;

  typedef enum logic [STATE_W-1:0] {
    ST_IDLE     = 3'd0,
    ST_ENTRY    = 3'd1,
    ST_UNLOCKED = 3'd2,
    ST_LOCKOUT  = 3'd3
  } pw_state_e;

endpackage

// File: rtl/pw_access_ctrl_if.sv
// rtl/pw_access_ctrl_if.sv - switch/checker/display signal bundle for pw_access_ctrl
interface pw_access_ctrl_if;
  import pw_pkg::*;

  logic                tick;
  logic [SW_W-1:0]     sw_pulse;
  logic                check_done;
  logic                check_pass;
  logic [SW_W-1:0]     sw_gated;
  logic                pw_clear;
  logic                unlocked;
  logic [STATE_W-1:0]  state_code;
  logic [3:0]          fail_count;
  logic [TIMER_W-1:0]  timer_secs;

  modport master (
    output tick, sw_pulse, check_done, check_pass,
    input  sw_gated, pw_clear, unlocked, state_code, fail_count, timer_secs
  );

  modport slave (
    input  tick, sw_pulse, check_done, check_pass,
    output sw_gated, pw_clear, unlocked, state_code, fail_count, timer_secs
  );

endinterface

// File: rtl/pw_sec_timer.sv
// rtl/pw_sec_timer.sv - loadable seconds down-counter; zero_evt_o flags the tick that takes it 1 -> 0
module pw_sec_timer
  import pw_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               load_i,
  input  logic [TIMER_W-1:0] load_val_i,
  input  logic               tick_i,
  output logic [TIMER_W-1:0] count_o,
  output logic               zero_evt_o
);

  logic [TIMER_W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (load_i) begin
      count_d = load_val_i;
    end else if (tick_i && (count_q != '0)) begin
      count_d = count_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  // Not gated by load_i so the caller can rank reload against expiry without a comb loop.
  assign zero_evt_o = tick_i && (count_q == TIMER_W'(1));
  assign count_o    = count_q;

endmodule

// File: rtl/pw_access_ctrl.sv
// rtl/pw_access_ctrl.sv - access sequencer for the switch-password lock
// PW_ESCALATE_EN: doubles the lockout time per consecutive lockout (saturating at 4x).
module pw_access_ctrl
  import pw_pkg::*;
#(
  parameter int unsigned MAX_FAILS   = 3,
  parameter int unsigned LOCK_SECS   = 30,
  parameter int unsigned UNLOCK_SECS = 10,
  parameter int unsigned IDLE_SECS   = 5
) (
  input  logic           clk,
  input  logic           rst,
  pw_access_ctrl_if.slave bus
);

  localparam logic [3:0]         MAX_F    = 4'(MAX_FAILS);
  localparam logic [TIMER_W-1:0] LOCK_T   = TIMER_W'(LOCK_SECS);
  localparam logic [TIMER_W-1:0] UNLOCK_T = TIMER_W'(UNLOCK_SECS);
  localparam logic [TIMER_W-1:0] IDLE_T   = TIMER_W'(IDLE_SECS);

  pw_state_e          state_q, state_d;
  logic [3:0]         fail_q, fail_d;
  logic               clr_q, clr_d;
  logic               t_load;
  logic [TIMER_W-1:0] t_val;
  logic [TIMER_W-1:0] t_count;
  logic               t_zero;
  logic [TIMER_W-1:0] lock_val;
  logic               any_sw;

`ifdef PW_ESCALATE_EN
  logic [1:0] level_q, level_d;
  assign lock_val = LOCK_T << level_q;
`else
  assign lock_val = LOCK_T;
`endif

  assign any_sw = |bus.sw_pulse;

  pw_sec_timer u_timer (
    .clk        (clk),
    .rst        (rst),
    .load_i     (t_load),
    .load_val_i (t_val),
    .tick_i     (bus.tick),
    .count_o    (t_count),
    .zero_evt_o (t_zero)
  );

  always_comb begin
    state_d = state_q;
    fail_d  = fail_q;
    clr_d   = 1'b0;
    t_load  = 1'b0;
    t_val   = '0;
`ifdef PW_ESCALATE_EN
    level_d = level_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (any_sw) begin
          state_d = ST_ENTRY;
          t_load  = 1'b1;
          t_val   = IDLE_T;
        end
      end
      ST_ENTRY: begin
        // Verdict outranks both reload and timeout.
        if (bus.check_done) begin
          if (bus.check_pass) begin
            state_d = ST_UNLOCKED;
            fail_d  = '0;
            t_load  = 1'b1;
            t_val   = UNLOCK_T;
`ifdef PW_ESCALATE_EN
            level_d = '0;
`endif
          end else if (fail_q + 4'd1 == MAX_F) begin
            state_d = ST_LOCKOUT;
            fail_d  = MAX_F;
            t_load  = 1'b1;
            t_val   = lock_val;
`ifdef PW_ESCALATE_EN
            level_d = (level_q == 2'd2) ? 2'd2 : level_q + 2'd1;
`endif
          end else begin
            state_d = ST_IDLE;
            fail_d  = fail_q + 4'd1;
            clr_d   = 1'b1;
            t_load  = 1'b1;
          end
        end else if (any_sw) begin
          t_load = 1'b1;
          t_val  = IDLE_T;
        end else if (t_zero) begin
          state_d = ST_IDLE;
          clr_d   = 1'b1;
        end
      end
      ST_UNLOCKED: begin
        if (bus.sw_pulse[LOCK_KEY_BIT]) begin
          state_d = ST_IDLE;
          clr_d   = 1'b1;
          t_load  = 1'b1;
        end else if (t_zero) begin
          state_d = ST_IDLE;
          clr_d   = 1'b1;
        end
      end
      ST_LOCKOUT: begin
        if (t_zero) begin
          state_d = ST_IDLE;
          fail_d  = '0;
          clr_d   = 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
        t_load  = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      fail_q  <= '0;
      clr_q   <= 1'b0;
`ifdef PW_ESCALATE_EN
      level_q <= '0;
`endif
    end else begin
      state_q <= state_d;
      fail_q  <= fail_d;
      clr_q   <= clr_d;
`ifdef PW_ESCALATE_EN
      level_q <= level_d;
`endif
    end
  end

  assign bus.sw_gated   = (state_q == ST_IDLE || state_q == ST_ENTRY) ? bus.sw_pulse : '0;
  assign bus.pw_clear   = clr_q;
  assign bus.unlocked   = (state_q == ST_UNLOCKED);
  assign bus.state_code = state_q;
  assign bus.fail_count = fail_q;
  assign bus.timer_secs = t_count;

endmodule
